// File: rtl/atari_bus_cycle_tracker.sv
// rtl/atari_bus_cycle_tracker.sv - Atari bus synchronizer, PHI2 glitch filter and per-cycle framer
module atari_bus_cycle_tracker #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 3,
    parameter int STALL_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    input  logic        phi2,
    input  logic        rw,
    input  logic        halt,
    output logic        phi2_clean,
    output logic        cyc_start,
    output logic [15:0] cyc_addr,
    output logic        cyc_rw,
    output logic        cyc_dma,
    output logic        rd_window,
    output logic        wr_strobe,
    output logic [7:0]  wr_data,
    output logic        stall,
    output logic [7:0]  glitch_count
);
    typedef enum logic {S_LOW, S_HIGH} state_t;

    localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] STALL_LIM = 16'(STALL_CYCLES);

    logic [SYNC_STAGES-1:0][15:0] a_sync;
    logic [SYNC_STAGES-1:0][7:0]  d_sync;
    logic [SYNC_STAGES-1:0]       phi2_sync;
    logic [SYNC_STAGES-1:0]       rw_sync;
    logic [SYNC_STAGES-1:0]       halt_sync;

    logic [15:0] a_s;
    logic [7:0]  d_s;
    logic        phi2_s;
    logic        rw_s;
    logic        halt_s;

    logic [3:0]  filt_cnt;
    logic [7:0]  d_hold;
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt_next;
    logic        stall_next;
    logic        phi2_edge;

    state_t state;
    state_t state_next;
    logic   cyc_start_next;
    logic   wr_strobe_next;
    logic   rd_next;
    logic   load_cyc;

    assign a_s    = a_sync[SYNC_STAGES-1];
    assign d_s    = d_sync[SYNC_STAGES-1];
    assign phi2_s = phi2_sync[SYNC_STAGES-1];
    assign rw_s   = rw_sync[SYNC_STAGES-1];
    assign halt_s = halt_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync    <= '0;
            d_sync    <= '0;
            phi2_sync <= '0;
            rw_sync   <= '0;
            halt_sync <= '0;
        end else begin
            a_sync    <= {a_sync[SYNC_STAGES-2:0], a};
            d_sync    <= {d_sync[SYNC_STAGES-2:0], d_in};
            phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], phi2};
            rw_sync   <= {rw_sync[SYNC_STAGES-2:0], rw};
            halt_sync <= {halt_sync[SYNC_STAGES-2:0], halt};
        end
    end

    // A nonzero counter at the moment the levels agree again means a pulse was rejected.
    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_clean   <= 1'b0;
            filt_cnt     <= '0;
            glitch_count <= '0;
        end else if (phi2_s == phi2_clean) begin
            filt_cnt <= '0;
            if (filt_cnt != 4'd0 && glitch_count != 8'hFF)
                glitch_count <= glitch_count + 8'd1;
        end else if (filt_cnt == FILT_LAST) begin
            phi2_clean <= ~phi2_clean;
            filt_cnt   <= '0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    // The FSM trails phi2_clean by one clk, so a level mismatch marks a fresh edge.
    assign phi2_edge      = phi2_clean != (state == S_HIGH);
    assign stall_cnt_next = phi2_edge ? 16'd0 :
                            (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
    assign stall_next     = !phi2_edge && (stall_cnt_next >= STALL_LIM);

    always_comb begin
        state_next     = state;
        cyc_start_next = 1'b0;
        wr_strobe_next = 1'b0;
        rd_next        = rd_window;
        load_cyc       = 1'b0;
        unique case (state)
            S_LOW: begin
                if (phi2_clean) begin
                    state_next     = S_HIGH;
                    cyc_start_next = 1'b1;
                    load_cyc       = 1'b1;
                    rd_next        = rw_s;
                end
            end
            S_HIGH: begin
                if (!phi2_clean) begin
                    state_next     = S_LOW;
                    rd_next        = 1'b0;
                    wr_strobe_next = ~cyc_rw;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOW;
            cyc_start <= 1'b0;
            wr_strobe <= 1'b0;
            rd_window <= 1'b0;
            stall     <= 1'b0;
            stall_cnt <= '0;
            cyc_addr  <= 16'h0000;
            cyc_rw    <= 1'b1;
            cyc_dma   <= 1'b0;
            wr_data   <= 8'h00;
            d_hold    <= 8'h00;
        end else begin
            state     <= state_next;
            cyc_start <= cyc_start_next;
            wr_strobe <= wr_strobe_next;
            rd_window <= rd_next & ~stall_next;
            stall     <= stall_next;
            stall_cnt <= stall_cnt_next;
            if (phi2_clean)
                d_hold <= d_s;
            if (load_cyc) begin
                cyc_addr <= a_s;
                cyc_rw   <= rw_s;
                cyc_dma  <= ~halt_s;
            end
            if (wr_strobe_next)
                wr_data <= d_hold;
        end
    end
endmodule

// File: tb/tb_atari_bus_cycle_tracker.sv
// tb/tb_atari_bus_cycle_tracker.sv - Scoreboard bench for atari_bus_cycle_tracker
module tb_atari_bus_cycle_tracker;
    localparam int LAT   = 6;
    localparam int STALL = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic        phi2, rw, halt;
    logic        phi2_clean, cyc_start, cyc_rw, cyc_dma, rd_window, wr_strobe, stall;
    logic [15:0] cyc_addr;
    logic [7:0]  wr_data, glitch_count;

    atari_bus_cycle_tracker #(.SYNC_STAGES(2), .FILTER_LEN(3), .STALL_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .a(a), .d_in(d_in), .phi2(phi2), .rw(rw), .halt(halt),
        .phi2_clean(phi2_clean), .cyc_start(cyc_start), .cyc_addr(cyc_addr),
        .cyc_rw(cyc_rw), .cyc_dma(cyc_dma), .rd_window(rd_window), .wr_strobe(wr_strobe),
        .wr_data(wr_data), .stall(stall), .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [15:0] addr; logic rw; logic dma; } cyc_exp_t;
    typedef struct { int t; logic [7:0] data; } wr_exp_t;
    typedef struct { int rise; int fall; } stall_exp_t;

    cyc_exp_t   exp_cyc[$];
    wr_exp_t    exp_wr[$];
    int         exp_rd[$];
    stall_exp_t exp_stall[$];

    int checks = 0;
    int errors = 0;
    int glitches = 0;
    int ph_start = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cyc %0d", name, act, exp, cyc);
        end
    endfunction

    // Each accepted raw PHI2 edge closes a phase; phases longer than STALL clks stall.
    task automatic accept_edge(input int t);
        if (t - ph_start > STALL)
            exp_stall.push_back('{ph_start + LAT + STALL, t + LAT});
        ph_start = t;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic seg_high(input int len, input logic [15:0] addr, input logic rd,
                            input logic dma, input logic [7:0] data);
        int r;
        a = addr; rw = rd; halt = ~dma; d_in = data; phi2 = 1'b1;
        r = cyc;
        if (len >= 3) begin
            exp_cyc.push_back('{r + LAT, addr, rd, dma});
            accept_edge(r);
            accept_edge(r + len);
            if (rd) exp_rd.push_back(len > STALL ? STALL : len);
            else    exp_wr.push_back('{r + len + LAT, data});
        end else begin
            glitches++;
        end
        tick(len);
    endtask

    task automatic seg_low(input int len);
        phi2 = 1'b0;
        tick(len);
    endtask

    int         rd_run = 0;
    int         stall_rise_t = 0;
    logic       stall_q = 1'b0;
    cyc_exp_t   ce;
    wr_exp_t    we;
    stall_exp_t se;

    always @(negedge clk) begin
        if (!rst) begin
            if (cyc_start && wr_strobe) chk("start_and_strobe", 1, 0);
            if (cyc_start) begin
                if (exp_cyc.size() == 0) chk("unexpected_cyc_start", 1, 0);
                else begin
                    ce = exp_cyc.pop_front();
                    chk("cyc_start_time", cyc, ce.t);
                    chk("cyc_addr", cyc_addr, ce.addr);
                    chk("cyc_rw", cyc_rw, ce.rw);
                    chk("cyc_dma", cyc_dma, ce.dma);
                end
            end
            if (wr_strobe) begin
                if (exp_wr.size() == 0) chk("unexpected_wr_strobe", 1, 0);
                else begin
                    we = exp_wr.pop_front();
                    chk("wr_strobe_time", cyc, we.t);
                    chk("wr_data", wr_data, we.data);
                end
            end
            if (rd_window) rd_run++;
            else if (rd_run > 0) begin
                if (exp_rd.size() == 0) chk("unexpected_rd_window", rd_run, 0);
                else chk("rd_window_len", rd_run, exp_rd.pop_front());
                rd_run = 0;
            end
            if (stall && !stall_q) stall_rise_t = cyc;
            if (!stall && stall_q) begin
                if (exp_stall.size() == 0) chk("unexpected_stall", stall_rise_t, 0);
                else begin
                    se = exp_stall.pop_front();
                    chk("stall_rise_time", stall_rise_t, se.rise);
                    chk("stall_fall_time", cyc, se.fall);
                end
            end
            stall_q = stall;
        end
    end

    initial begin
        int t0;
        rst = 1'b1; phi2 = 1'b1; a = 16'h4123; rw = 1'b1; halt = 1'b1; d_in = 8'h00;
        tick(3);
        chk("rst_phi2_clean", phi2_clean, 0);
        chk("rst_cyc_start", cyc_start, 0);
        chk("rst_cyc_addr", cyc_addr, 16'h0000);
        chk("rst_cyc_rw", cyc_rw, 1);
        chk("rst_cyc_dma", cyc_dma, 0);
        chk("rst_rd_window", rd_window, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_stall", stall, 0);
        chk("rst_glitch_count", glitch_count, 0);
        rst = 1'b0;
        t0 = cyc;
        ph_start = t0;
        fork
            begin
                tick(4);
                chk("reset_latency_early", phi2_clean, 0);
                tick(1);
                chk("reset_latency_exact", phi2_clean, 1);
            end
        join_none

        seg_high(8, 16'h4123, 1'b1, 1'b0, 8'h00);
        seg_low(6);
        seg_high(6, 16'h0450, 1'b0, 1'b0, 8'hA5);
        seg_low(6);
        seg_high(2, 16'h1111, 1'b1, 1'b0, 8'h00);
        seg_low(6);
        chk("glitch_first", glitch_count, 1);
        seg_high(5, 16'hC000, 1'b1, 1'b1, 8'h00);
        seg_low(6);
        seg_high(100, 16'h2345, 1'b1, 1'b0, 8'h00);
        seg_low(6);
        seg_high(90, 16'h2346, 1'b0, 1'b0, 8'h3C);
        seg_low(6);

        for (int i = 0; i < 150; i++) begin
            int hl, ll;
            hl = ($urandom_range(9, 0) == 0) ? $urandom_range(90, 60) : $urandom_range(12, 1);
            ll = ($urandom_range(9, 0) == 0) ? $urandom_range(80, 60) : $urandom_range(12, 4);
            seg_high(hl, 16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            seg_low(ll);
        end

        for (int i = 0; i < 300; i++) begin
            seg_high(2, 16'($urandom), 1'b1, 1'b0, 8'h00);
            seg_low(4);
        end
        seg_high(5, 16'hBEEF, 1'b0, 1'b0, 8'h5A);
        seg_low(15);

        chk("glitch_count_sat", glitch_count, glitches > 255 ? 255 : glitches);
        chk("pending_cyc", exp_cyc.size(), 0);
        chk("pending_wr", exp_wr.size(), 0);
        chk("pending_rd", exp_rd.size(), 0);
        chk("pending_stall", exp_stall.size(), 0);
        chk("final_stall", stall, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/atari_bus_cycle_tracker.md
Name: atari_bus_cycle_tracker

Overview:
Front-end stage that sits directly upstream of the cartridge ROM/drive logic. It synchronizes the raw Atari bus signals into the 27 MHz domain and glitch-filters PHI2. It frames each 6502/MARIA bus cycle and emits a clean, latched per-cycle view: address, direction, DMA flag, read window and write strobe with data. The ROM fetch, buffer-enable and bank/register logic consume these outputs instead of raw pins.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers for a, d, phi2, rw, halt (min 2).
FILTER_LEN, 3, consecutive synced PHI2 samples at the new level required before phi2_clean changes (1..15).
STALL_CYCLES, 64, clk cycles without a phi2_clean edge before stall asserts (must be < 65536).

Ports:
clk  in  1  27 MHz system clock.
rst  in  1  synchronous reset, active-high.
a  in  16  raw Atari address bus.
d_in  in  8  raw data bus, input side of the bidirectional pad.
phi2  in  1  raw Phase 2 clock.
rw  in  1  raw R/W (1 = read).
halt  in  1  raw HALT (0 = MARIA DMA).
phi2_clean  out  1  synchronized, filtered PHI2.
cyc_start  out  1  one-clk pulse on the phi2_clean rising edge.
cyc_addr  out  16  address latched at cyc_start.
cyc_rw  out  1  rw latched at cyc_start.
cyc_dma  out  1  ~halt latched at cyc_start.
rd_window  out  1  high while a latched read cycle is in its high phase.
wr_strobe  out  1  one-clk pulse at the end of a write cycle.
wr_data  out  8  data captured for the write, valid with wr_strobe and held until the next write.
stall  out  1  PHI2 edge timeout flag.
glitch_count  out  8  saturating count of rejected PHI2 pulses.

Behaviour:
- Reset (rst=1 at posedge clk):
  - Synchronizer chains cleared to 0.
  - phi2_clean=0, filter counter=0, state=S_LOW.
  - cyc_start=0, wr_strobe=0, rd_window=0, stall=0.
  - cyc_addr=16'h0000, cyc_rw=1, cyc_dma=0, wr_data=8'h00.
  - glitch_count=0, stall counter=0.
  - Reset asserted mid-cycle aborts that cycle; no strobe is emitted for it.
- Synchronizers: every input is passed through SYNC_STAGES flops. Below, "synced" refers to the last stage.
- Filter:
  - While synced phi2 == phi2_clean, the counter is held at 0.
  - While they differ, the counter increments each clk.
  - When the counter reaches FILTER_LEN-1 while they still differ, phi2_clean flips on the next edge and the counter returns to 0.
  - If synced phi2 returns to the phi2_clean level before the flip, the counter clears and glitch_count increments (saturates at 255).
  - Raw-edge-to-phi2_clean latency is exactly SYNC_STAGES+FILTER_LEN clks.
- FSM (S_LOW, S_HIGH):
  - S_LOW -> S_HIGH on the phi2_clean rising edge:
    - cyc_start=1 for one clk.
    - cyc_addr, cyc_rw and cyc_dma load from the synced a, rw and ~halt of that same clk.
    - rd_window goes high on that same clk if synced rw=1.
  - S_HIGH -> S_LOW on the phi2_clean falling edge:
    - rd_window=0 on that clk.
    - If cyc_rw=0: wr_strobe=1 for one clk, and wr_data = synced d_in sampled on the last clk that phi2_clean was high.
  - Outputs are registered. cyc_start and wr_strobe never assert on the same clk.
- Stall:
  - A 16-bit counter clears on every phi2_clean edge and otherwise increments, saturating.
  - stall=1 when the counter reaches STALL_CYCLES. rd_window is forced to 0 while stall=1.
  - stall clears on the clk of the next phi2_clean edge.
  - A cycle that stalls in S_HIGH with cyc_rw=0 still emits wr_strobe on its eventual falling edge.
- cyc_* outputs hold their values between cycles; they are updated only at cyc_start.

Test Plan:
- Reset: drive rst=1 for 3 clks with phi2=1 -> all outputs at their reset values; after release, phi2_clean=1 exactly SYNC_STAGES+FILTER_LEN (=5) clks later.
- Read cycle: phi2 high for 8 clks, a=16'h4123, rw=1, halt=1 -> cyc_start pulses once, cyc_addr=16'h4123, cyc_rw=1, cyc_dma=0, rd_window high for 8 clks, wr_strobe=0.
- Write cycle: a=16'h0450, rw=0, d_in=8'hA5 stable through the high phase -> wr_strobe pulses one clk after phi2_clean falls, wr_data=8'hA5, rd_window stays 0.
- Glitch: a 2-clk PHI2 high pulse with FILTER_LEN=3 -> phi2_clean stays 0, no cyc_start, glitch_count increments 0->1; 300 such pulses -> glitch_count=255.
- DMA: halt=0 during a read of 16'hC000 -> cyc_dma=1 and rd_window is asserted normally.
- Stall: phi2 held high for 100 clks -> stall=1 at STALL_CYCLES (64) clks after the rising edge, rd_window drops on that clk, and both stall and rd_window stay low-active/cleared correctly on the next falling edge.
